// File: rtl/uart_tx_sched.sv
// Two-requester UART transmitter: round-robin accept in IDLE, then one 8N1 frame
// at the bit rate latched in the accept cycle.
`timescale 1ns/1ps
module uart_tx_sched #(
  parameter int CLK_FREQ = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] baud_rate,
  input  logic [1:0] req_valid,
  input  logic [7:0] req_data0,
  input  logic [7:0] req_data1,
  output logic [1:0] req_ready,
  output logic       tx,
  output logic       busy,
  output logic       grant_id,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // Bit periods are stored minus one so the largest legal CLK_FREQ still fits 16 bits.
  localparam logic [15:0] CYC_M1_2400  = 16'(CLK_FREQ / 2400 - 1);
  localparam logic [15:0] CYC_M1_4800  = 16'(CLK_FREQ / 4800 - 1);
  localparam logic [15:0] CYC_M1_9600  = 16'(CLK_FREQ / 9600 - 1);
  localparam logic [15:0] CYC_M1_19200 = 16'(CLK_FREQ / 19200 - 1);

  state_t      state, state_n;
  logic [15:0] cnt;
  logic [15:0] bit_m1;
  logic [15:0] baud_m1;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        rr_prio;
  logic        accept;
  logic        grant_sel;
  logic        bit_end;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    req_ready = '0;
    accept    = 1'b0;
    grant_sel = 1'b0;
    done      = 1'b0;
    tx        = 1'b1;
    busy      = (state != IDLE);
    bit_end   = (cnt == bit_m1);
    baud_m1   = CYC_M1_19200;
    case (baud_rate)
      2'b00:   baud_m1 = CYC_M1_2400;
      2'b01:   baud_m1 = CYC_M1_4800;
      2'b10:   baud_m1 = CYC_M1_9600;
      default: baud_m1 = CYC_M1_19200;
    endcase
    case (state)
      IDLE: begin
        if (|req_valid) begin
          accept    = 1'b1;
          // rr_prio names the requester that wins when both are asking.
          grant_sel = (&req_valid) ? rr_prio : req_valid[1];
          req_ready = grant_sel ? 2'b10 : 2'b01;
          state_n   = START;
        end
      end
      START: begin
        tx = 1'b0;
        if (bit_end) state_n = DATA;
      end
      DATA: begin
        tx = shreg[bit_idx];
        if (bit_end && bit_idx == 3'd7) state_n = STOP;
      end
      STOP: begin
        if (bit_end) begin
          done    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      bit_m1   <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      grant_id <= 1'b0;
      rr_prio  <= 1'b0;
    end else if (accept) begin
      shreg    <= grant_sel ? req_data1 : req_data0;
      bit_m1   <= baud_m1;
      grant_id <= grant_sel;
      rr_prio  <= ~grant_sel;
      cnt      <= '0;
      bit_idx  <= '0;
    end else if (state != IDLE) begin
      if (bit_end) begin
        cnt <= '0;
        if (state == DATA) bit_idx <= bit_idx + 3'd1;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end

endmodule
